work_packet_tx: RTL
===================

WORK_PACKET_TX -- requirements
Module: work_packet_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit period (valid range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one work packet; sampled every cycle.
REQ-005 SHALL have port midstate  input  256  SHA-256 midstate to send; sampled only on an accepted start.
REQ-006 SHALL have port data2  input  256  second-block data word to send; sampled only on an accepted start.
REQ-007 SHALL have port TxD  output  1  UART serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a packet is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse at packet completion.

Function
REQ-010 SHALL send a work packet as 64 UART 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity, no inter-frame gap.
REQ-011 SHALL send bytes in order midstate[7:0], midstate[15:8] ... midstate[255:248], then data2[7:0] ... data2[255:248].
REQ-012 SHALL accept start only when busy=0 at the sampling edge; start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-013 SHALL register midstate and data2 into a 512-bit shift register on acceptance; input changes afterwards SHALL NOT affect the packet in flight.
REQ-014 SHALL raise busy and drive TxD=0 (first start bit) on the cycle after acceptance.
REQ-015 SHALL hold each bit level on TxD for exactly CLKS_PER_BIT cycles, timed by a baud counter reloaded at every bit boundary.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on accepted start; START->DATA after one bit period; DATA->STOP after 8 bit periods (3-bit bit index); STOP->START if byte index<63, else STOP->IDLE.
REQ-017 SHALL use a 6-bit byte index, incremented at each STOP exit, wrapping to 0 on return to IDLE.
REQ-018 SHALL hold busy high for exactly 640*CLKS_PER_BIT cycles per packet.
REQ-019 SHALL drive busy=0 and done=1 for one cycle on the first cycle after the last stop bit period; done SHALL be 0 at all other times.
REQ-020 SHALL accept a start that is high in the same cycle as done, so back-to-back packets have no idle bit time between them.
REQ-021 SHALL drive TxD=1 whenever in IDLE.
REQ-022 SHALL drive all outputs from registers (glitch-free TxD).

Reset
REQ-023 SHALL, while reset=1, force TxD=1, busy=0, done=0, FSM=IDLE, and counters=0, on the next clock edge.
REQ-024 SHALL, on reset mid-packet, abort the packet immediately, with no partial frame completion and no done pulse.
REQ-025 SHALL give reset priority over start in the same cycle.

Verification
REQ-026 SHALL be verified with CLKS_PER_BIT=4: start with midstate=0x...0201 (byte0=0x01, byte1=0x02), data2=0 -> TxD bits for frame 0 are 0,1,0,0,0,0,0,0,0,1, each lasting 4 cycles; busy high for 2560 cycles; exactly one done pulse.
REQ-027 SHALL be verified by a UART monitor decoding all 64 frames with random midstate and data2 -> the decoded bytes re-assemble exactly to {data2, midstate}.
REQ-028 SHALL be verified by pulsing start again at cycle 100 of a packet with different data -> it is ignored, the first packet completes unchanged, and no second packet follows.
REQ-029 SHALL be verified by holding start high continuously -> packets run back to back, done pulses every 2560 cycles, and TxD never idles a full bit period between packets.
REQ-030 SHALL be verified by asserting reset at cycle 1000 of a packet -> TxD=1, busy=0 on the next cycle, no done pulse, and a subsequent start sends a full, correct packet.
REQ-031 SHALL be verified by asserting start and reset together in one cycle -> nothing is sent and busy stays 0.

Source files
------------

// File: rtl/work_packet_tx.sv
// UART transmitter for one 64-byte mining work packet: midstate bytes then data2 bytes,
// LSB-first 8N1 frames sent back to back, with busy/done handshake.
module work_packet_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         TxD,
    output logic         busy,
    output logic         done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [5:0]     byte_idx_reg, byte_idx_next;
    logic [511:0]   pkt_reg, pkt_next;
    logic           txd_reg, txd_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic           bit_tick;

    assign bit_tick = (baud_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            pkt_reg      <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            pkt_reg      <= pkt_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so TxD/busy/done come straight from flops.
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        pkt_next      = pkt_reg;
        txd_next      = txd_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
                if (start) begin
                    state_next    = START;
                    baud_next     = BAUD_RELOAD;
                    bit_idx_next  = '0;
                    byte_idx_next = '0;
                    pkt_next      = {data2, midstate};
                    txd_next      = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    baud_next    = BAUD_RELOAD;
                    bit_idx_next = '0;
                    txd_next     = pkt_reg[0];
                end else begin
                    baud_next = baud_reg - CW'(1);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    // After eight shifts the next byte sits in pkt_reg[7:0].
                    baud_next = BAUD_RELOAD;
                    pkt_next  = pkt_reg >> 1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        txd_next     = pkt_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - CW'(1);
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (byte_idx_reg == 6'd63) begin
                        state_next    = IDLE;
                        baud_next     = '0;
                        byte_idx_next = '0;
                        txd_next      = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        state_next    = START;
                        baud_next     = BAUD_RELOAD;
                        byte_idx_next = byte_idx_reg + 6'd1;
                        txd_next      = 1'b0;
                    end
                end else begin
                    baud_next = baud_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign TxD  = txd_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
